// File: rtl/histogram_ctrl.sv
// Frame sequencer for the histogram datapath: accumulate, wait done, stream every bin out, then clear the RAM.
// Latency: frame_end to first o_out_valid = 1 + hist_done wait + RD_LAT + 1 cycles; one beat per RD_LAT+1 cycles at best.
// Backpressure: a presented beat holds while o_out_ready is low, for as long as it stays low; the bin sweep stalls with it.
module histogram_ctrl #(
  parameter int NUM_BINS     = 1024,
  parameter int RD_LAT       = 2,
  parameter int DONE_TIMEOUT = 4096
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_frame_start,
  input  logic        i_frame_end,
  output logic        o_hist_rw,
  output logic        o_pix_gate,
  output logic        o_hist_image_done,
  input  logic        i_hist_done,
  output logic [9:0]  o_hist_bin,
  input  logic [23:0] i_hist_data,
  output logic        o_clr_we,
  output logic [9:0]  o_clr_addr,
  output logic        o_out_valid,
  input  logic        i_out_ready,
  output logic [23:0] o_out_data,
  output logic [9:0]  o_out_bin,
  output logic        o_out_last,
  output logic [31:0] o_frame_sum,
  output logic        o_sum_valid,
  output logic        o_busy,
  output logic        o_err_drop,
  output logic        o_err_timeout
);

  // Timer must reach DONE_TIMEOUT-1; read-latency counter must reach RD_LAT-1.
  localparam int TW = $clog2(DONE_TIMEOUT + 1);
  localparam int LW = $clog2(RD_LAT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCUM,
    S_WAIT_DONE,
    S_FETCH,
    S_PRESENT,
    S_CLEAR
  } state_t;

  state_t        r_state;
  logic [10:0]   r_bin;        // one bit wider than the address so NUM_BINS=1024 terminal count is visible
  logic [TW-1:0] r_timer;
  logic [LW-1:0] r_lat;
  logic          r_rst_q;      // high for the first cycle after reset releases
  logic          r_hist_rw;
  logic          r_pix_gate;
  logic          r_image_done;
  logic          r_clr_we;
  logic          r_out_valid;
  logic [23:0]   r_out_data;
  logic [9:0]    r_out_bin;
  logic          r_out_last;
  logic [31:0]   r_frame_sum;
  logic          r_sum_valid;
  logic          r_err_drop;
  logic          r_err_timeout;

  logic [10:0]   w_bin_inc;
  logic          w_bin_last;
  logic          w_timer_exp;
  logic          w_lat_done;

  assign w_bin_inc   = r_bin + 11'd1;
  assign w_bin_last  = (w_bin_inc == 11'(NUM_BINS));
  assign w_timer_exp = (r_timer == TW'(DONE_TIMEOUT - 1));
  assign w_lat_done  = (r_lat == LW'(RD_LAT - 1));

  // Frame sequence: accumulate, wait for the datapath, fetch/present each bin, clear sweep.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= S_IDLE;
      r_bin         <= '0;
      r_timer       <= '0;
      r_lat         <= '0;
      r_rst_q       <= 1'b1;
      r_hist_rw     <= 1'b1;
      r_pix_gate    <= 1'b0;
      r_image_done  <= 1'b0;
      r_clr_we      <= 1'b0;
      r_out_valid   <= 1'b0;
      r_out_data    <= '0;
      r_out_bin     <= '0;
      r_out_last    <= 1'b0;
      r_frame_sum   <= '0;
      r_sum_valid   <= 1'b0;
      r_err_drop    <= 1'b0;
      r_err_timeout <= 1'b0;
    end else begin
      r_rst_q      <= 1'b0;
      r_image_done <= 1'b0;
      r_sum_valid  <= 1'b0;

      // A new frame cannot be taken while one is in flight; record it and carry on.
      if (i_frame_start && (r_state != S_IDLE)) begin
        r_err_drop <= 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (i_frame_start && !r_rst_q) begin
            r_state     <= S_ACCUM;
            r_pix_gate  <= 1'b1;
            r_hist_rw   <= 1'b1;
            r_frame_sum <= '0;
          end
        end

        S_ACCUM: begin
          if (i_frame_end) begin
            r_state      <= S_WAIT_DONE;
            r_pix_gate   <= 1'b0;
            r_image_done <= 1'b1;
            r_timer      <= '0;
          end
        end

        S_WAIT_DONE: begin
          // A timeout still reads out whatever the RAM holds rather than hanging the frame.
          if (i_hist_done || w_timer_exp) begin
            if (!i_hist_done) begin
              r_err_timeout <= 1'b1;
            end
            r_state   <= S_FETCH;
            r_hist_rw <= 1'b0;
            r_bin     <= '0;
            r_lat     <= '0;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end

        S_FETCH: begin
          if (w_lat_done) begin
            r_state     <= S_PRESENT;
            r_out_valid <= 1'b1;
            r_out_data  <= i_hist_data;
            r_out_bin   <= r_bin[9:0];
            r_out_last  <= w_bin_last;
          end else begin
            r_lat <= r_lat + LW'(1);
          end
        end

        S_PRESENT: begin
          if (i_out_ready) begin
            r_out_valid <= 1'b0;
            r_frame_sum <= r_frame_sum + {8'd0, r_out_data};
            if (r_out_last) begin
              r_state     <= S_CLEAR;
              r_out_last  <= 1'b0;
              r_sum_valid <= 1'b1;
              r_hist_rw   <= 1'b1;
              r_clr_we    <= 1'b1;
              r_bin       <= '0;
            end else begin
              r_state <= S_FETCH;
              r_bin   <= w_bin_inc;
              r_lat   <= '0;
            end
          end
        end

        S_CLEAR: begin
          if (w_bin_last) begin
            r_state  <= S_IDLE;
            r_clr_we <= 1'b0;
            r_bin    <= '0;
          end else begin
            r_bin <= w_bin_inc;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_hist_rw         = r_hist_rw;
  assign o_pix_gate        = r_pix_gate;
  assign o_hist_image_done = r_image_done;
  assign o_hist_bin        = r_bin[9:0];
  assign o_clr_we          = r_clr_we;
  assign o_clr_addr        = r_bin[9:0];
  assign o_out_valid       = r_out_valid;
  assign o_out_data        = r_out_data;
  assign o_out_bin         = r_out_bin;
  assign o_out_last        = r_out_last;
  assign o_frame_sum       = r_frame_sum;
  assign o_sum_valid       = r_sum_valid;
  assign o_busy            = (r_state != S_IDLE);
  assign o_err_drop        = r_err_drop;
  assign o_err_timeout     = r_err_timeout;

endmodule

// File: tb/tb_histogram_ctrl.sv
// Bench for histogram_ctrl: default instance plus a 16-bin, RD_LAT=4 instance.
// Datapath RAM modelled as a delay line on hist_bin feeding data = bin*mul + add.
// Expected beats queued when a frame is started and checked as the stream drains.
module tb_histogram_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        frame_start [2];
  logic        frame_end   [2];
  logic        hist_done   [2];
  logic        out_ready;
  logic        hist_rw     [2];
  logic        pix_gate    [2];
  logic        image_done  [2];
  logic [9:0]  hist_bin    [2];
  logic [23:0] hist_data   [2];
  logic        clr_we      [2];
  logic [9:0]  clr_addr    [2];
  logic        out_valid   [2];
  logic [23:0] out_data    [2];
  logic [9:0]  out_bin     [2];
  logic        out_last    [2];
  logic [31:0] frame_sum   [2];
  logic        sum_valid   [2];
  logic        busy        [2];
  logic        err_drop    [2];
  logic        err_timeout [2];

  histogram_ctrl u_a (
    .i_clk(clk), .i_rst(rst), .i_frame_start(frame_start[0]), .i_frame_end(frame_end[0]),
    .o_hist_rw(hist_rw[0]), .o_pix_gate(pix_gate[0]), .o_hist_image_done(image_done[0]),
    .i_hist_done(hist_done[0]), .o_hist_bin(hist_bin[0]), .i_hist_data(hist_data[0]),
    .o_clr_we(clr_we[0]), .o_clr_addr(clr_addr[0]), .o_out_valid(out_valid[0]),
    .i_out_ready(out_ready), .o_out_data(out_data[0]), .o_out_bin(out_bin[0]),
    .o_out_last(out_last[0]), .o_frame_sum(frame_sum[0]), .o_sum_valid(sum_valid[0]),
    .o_busy(busy[0]), .o_err_drop(err_drop[0]), .o_err_timeout(err_timeout[0])
  );

  histogram_ctrl #(.NUM_BINS(16), .RD_LAT(4), .DONE_TIMEOUT(64)) u_b (
    .i_clk(clk), .i_rst(rst), .i_frame_start(frame_start[1]), .i_frame_end(frame_end[1]),
    .o_hist_rw(hist_rw[1]), .o_pix_gate(pix_gate[1]), .o_hist_image_done(image_done[1]),
    .i_hist_done(hist_done[1]), .o_hist_bin(hist_bin[1]), .i_hist_data(hist_data[1]),
    .o_clr_we(clr_we[1]), .o_clr_addr(clr_addr[1]), .o_out_valid(out_valid[1]),
    .i_out_ready(out_ready), .o_out_data(out_data[1]), .o_out_bin(out_bin[1]),
    .o_out_last(out_last[1]), .o_frame_sum(frame_sum[1]), .o_sum_valid(sum_valid[1]),
    .o_busy(busy[1]), .o_err_drop(err_drop[1]), .o_err_timeout(err_timeout[1])
  );

  // Datapath model: data is valid RD_LAT edges after hist_bin changes (RD_LAT-1 flops).
  logic [23:0] dp_mul, dp_add;
  logic [9:0]  a_q;
  logic [9:0]  b_q [3];
  always @(posedge clk) begin
    a_q    <= hist_bin[0];
    b_q[0] <= hist_bin[1];
    b_q[1] <= b_q[0];
    b_q[2] <= b_q[1];
  end
  assign hist_data[0] = {14'd0, a_q} * dp_mul + dp_add;
  assign hist_data[1] = {14'd0, b_q[2]} * dp_mul + dp_add;

  function automatic logic [23:0] dp_f(input int k);
    return 24'(k) * dp_mul + dp_add;
  endfunction

  typedef struct packed {
    logic        inst;
    logic [9:0]  bin;
    logic [23:0] data;
    logic        last;
  } beat_t;

  beat_t       sbq [$];
  logic [31:0] exp_sum;
  bit          exp_drop [2];
  bit          exp_to   [2];
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks = n_checks + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Stream monitor: handshake pops the scoreboard, stalled beats must hold, sum checked on pulse.
  logic        prev_stall [2] = '{1'b0, 1'b0};
  logic [34:0] prev_beat  [2];
  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (prev_stall[g]) begin
        chk("stall_valid_held", out_valid[g], 1);
        chk("stall_beat_held", {out_last[g], out_bin[g], out_data[g]}, prev_beat[g]);
      end
      if (out_valid[g] && out_ready) begin
        chk("beat_expected", sbq.size() != 0, 1);
        if (sbq.size() != 0) begin
          chk("beat_inst", g, sbq[0].inst);
          chk("beat_bin", out_bin[g], sbq[0].bin);
          chk("beat_data", out_data[g], sbq[0].data);
          chk("beat_last", out_last[g], sbq[0].last);
          void'(sbq.pop_front());
        end
      end
      if (sum_valid[g]) begin
        chk("frame_sum_at_pulse", frame_sum[g], exp_sum);
        chk("no_bins_left_at_sum", sbq.size(), 0);
      end
      prev_stall[g] <= out_valid[g] && !out_ready && !rst;
      prev_beat[g]  <= {out_last[g], out_bin[g], out_data[g]};
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    for (int g = 0; g < 2; g++) begin
      exp_drop[g] = 1'b0;
      exp_to[g]   = 1'b0;
    end
    repeat (2) tick();
  endtask

  // One full frame on instance g. d = cycle after frame_end when hist_done rises (0 = never).
  task automatic run_frame(input int g, input int n, input int rdl, input int d, input int to,
                           input bit toggle, input bit drop_accum, input bit drop_present);
    int lat;
    int clr_n;
    bit seen_v, got_sum, clr_ok, dropped;
    clr_n = 0; seen_v = 0; got_sum = 0; clr_ok = 1; dropped = 0;

    frame_start[g] = 1'b1;
    tick();
    frame_start[g] = 1'b0;
    chk("accum_pix_gate", pix_gate[g], 1);
    chk("accum_busy", busy[g], 1);
    chk("accum_hist_rw", hist_rw[g], 1);
    chk("accum_sum_cleared", frame_sum[g], 0);
    if (drop_accum) begin
      frame_start[g] = 1'b1;
      tick();
      frame_start[g] = 1'b0;
      exp_drop[g] = 1'b1;
      chk("drop_in_accum_flag", err_drop[g], 1);
      chk("drop_in_accum_still_accum", pix_gate[g], 1);
    end
    repeat (2) tick();

    exp_sum = '0;
    for (int k = 0; k < n; k++) begin
      sbq.push_back('{inst: 1'(g), bin: 10'(k), data: dp_f(k), last: (k == n - 1)});
      exp_sum = exp_sum + {8'd0, dp_f(k)};
    end

    frame_end[g] = 1'b1;
    tick();
    frame_end[g] = 1'b0;
    chk("image_done_pulse", image_done[g], 1);
    chk("pix_gate_closed", pix_gate[g], 0);
    chk("wait_hist_rw", hist_rw[g], 1);

    lat = 1;
    while (!(got_sum && !busy[g]) && lat < 12000) begin
      hist_done[g] = (d > 0) && (lat >= d);
      out_ready    = toggle ? (lat % 3 == 0) : 1'b1;
      if (drop_present && out_valid[g] && !dropped) begin
        frame_start[g] = 1'b1;
        dropped = 1'b1;
        exp_drop[g] = 1'b1;
      end else begin
        frame_start[g] = 1'b0;
      end
      if (lat == 2) chk("image_done_one_cycle", image_done[g], 0);
      if (out_valid[g] && !seen_v) begin
        seen_v = 1'b1;
        chk("first_beat_latency", lat, ((d > 0) ? d : to) + rdl + 1);
        chk("read_mode_hist_rw", hist_rw[g], 0);
      end
      if (clr_we[g]) begin
        clr_ok = clr_ok && (clr_addr[g] == 10'(clr_n)) && hist_rw[g];
        clr_n++;
      end
      if (sum_valid[g]) got_sum = 1'b1;
      tick();
      lat++;
    end
    hist_done[g]   = 1'b0;
    frame_start[g] = 1'b0;
    out_ready      = 1'b1;

    chk("frame_finished_in_budget", got_sum && !busy[g], 1);
    chk("clear_cycle_count", clr_n, n);
    chk("clear_addr_sequence", clr_ok, 1);
    chk("scoreboard_drained", sbq.size(), 0);
    chk("idle_clr_we_low", clr_we[g], 0);
    chk("idle_hist_rw", hist_rw[g], 1);
    chk("err_drop_after_frame", err_drop[g], exp_drop[g]);
    chk("err_timeout_after_frame", err_timeout[g], exp_to[g]);
    sbq.delete();
  endtask

  initial begin
    int lat;
    bit reached;
    rst = 1'b1;
    out_ready = 1'b1;
    dp_mul = 24'd1;
    dp_add = 24'd0;
    for (int g = 0; g < 2; g++) begin
      frame_start[g] = 1'b0;
      frame_end[g]   = 1'b0;
      hist_done[g]   = 1'b0;
      exp_drop[g]    = 1'b0;
      exp_to[g]      = 1'b0;
    end
    repeat (3) tick();

    for (int g = 0; g < 2; g++) begin
      chk("rst_hist_rw", hist_rw[g], 1);
      chk("rst_busy", busy[g], 0);
      chk("rst_pix_gate", pix_gate[g], 0);
      chk("rst_out_valid", out_valid[g], 0);
      chk("rst_frame_sum", frame_sum[g], 0);
      chk("rst_err_drop", err_drop[g], 0);
      chk("rst_err_timeout", err_timeout[g], 0);
      chk("rst_clr_we", clr_we[g], 0);
      chk("rst_image_done", image_done[g], 0);
      chk("rst_sum_valid", sum_valid[g], 0);
    end

    // frame_start coincident with reset release is ignored.
    rst = 1'b0;
    frame_start[0] = 1'b1;
    tick();
    frame_start[0] = 1'b0;
    chk("start_at_rst_release_ignored", busy[0], 0);
    repeat (2) tick();

    // Basic frame, identity data, always ready.
    run_frame(0, 1024, 2, 3, 4096, 1'b0, 1'b0, 1'b0);
    chk("t1_frame_sum", frame_sum[0], 523776);

    // Same frame with ready asserted one cycle in three.
    run_frame(0, 1024, 2, 3, 4096, 1'b1, 1'b0, 1'b0);
    chk("t2_frame_sum", frame_sum[0], 523776);

    // hist_done never arrives; large values make frame_sum wrap.
    dp_mul = 24'd16411;
    dp_add = 24'hFFF000;
    exp_to[0] = 1'b1;
    run_frame(0, 1024, 2, 0, 4096, 1'b0, 1'b0, 1'b0);
    repeat (5) tick();
    chk("timeout_sticky", err_timeout[0], 1);
    do_reset();
    chk("timeout_cleared_by_rst", err_timeout[0], 0);

    // Dropped frame_start during ACCUM, then a clean frame is still accepted.
    dp_mul = 24'd3;
    dp_add = 24'd7;
    run_frame(0, 1024, 2, 5, 4096, 1'b0, 1'b1, 1'b0);
    run_frame(0, 1024, 2, 1, 4096, 1'b0, 1'b0, 1'b0);
    do_reset();

    // Dropped frame_start during PRESENT.
    run_frame(0, 1024, 2, 2, 4096, 1'b1, 1'b0, 1'b1);
    do_reset();

    // Reset while bin 500 is presented and stalled.
    dp_mul = 24'd1;
    dp_add = 24'd0;
    exp_sum = '0;
    for (int k = 0; k < 1024; k++) begin
      sbq.push_back('{inst: 1'b0, bin: 10'(k), data: dp_f(k), last: (k == 1023)});
    end
    frame_start[0] = 1'b1;
    tick();
    frame_start[0] = 1'b0;
    repeat (2) tick();
    frame_end[0] = 1'b1;
    tick();
    frame_end[0] = 1'b0;
    hist_done[0] = 1'b1;
    reached = 1'b0;
    lat = 0;
    while (!reached && lat < 4000) begin
      if (out_valid[0] && out_bin[0] == 10'd500) begin
        out_ready = 1'b0;
        reached = 1'b1;
      end else begin
        out_ready = 1'b1;
        tick();
        lat++;
      end
    end
    chk("t5_reached_bin500", reached, 1);
    rst = 1'b1;
    hist_done[0] = 1'b0;
    tick();
    chk("abort_out_valid", out_valid[0], 0);
    chk("abort_busy", busy[0], 0);
    chk("abort_frame_sum", frame_sum[0], 0);
    chk("abort_hist_rw", hist_rw[0], 1);
    chk("abort_clr_we", clr_we[0], 0);
    rst = 1'b0;
    out_ready = 1'b1;
    sbq.delete();
    repeat (2) tick();
    run_frame(0, 1024, 2, 3, 4096, 1'b0, 1'b0, 1'b0);
    chk("t5_recovered_sum", frame_sum[0], 523776);

    // Small instance: 16 bins, RD_LAT = 4.
    run_frame(1, 16, 4, 3, 64, 1'b0, 1'b0, 1'b0);
    chk("b_frame_sum", frame_sum[1], 120);
    run_frame(1, 16, 4, 2, 64, 1'b1, 1'b0, 1'b0);
    chk("b_frame_sum_toggle", frame_sum[1], 120);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
